// File: rtl/reg_file_nxw_2r1w.sv
// Parametrised DEPTH x WIDTH register file: two registered read ports, one
// bit-masked write port, same-cycle write-to-read bypass, per-entry valid bits
// with a single-cycle bulk clear.
module reg_file_nxw_2r1w #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned DEPTH  = 40,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [WIDTH-1:0]  wr_mask,
  input  logic              rd0_en,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic [WIDTH-1:0]  rd0_data,
  output logic              rd0_hit,
  output logic              rd0_vld,
  input  logic              rd1_en,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [WIDTH-1:0]  rd1_data,
  output logic              rd1_hit,
  output logic              rd1_vld,
  output logic [DEPTH-1:0]  valid_vec
);

  // One extra bit so DEPTH == 2^ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DepthC = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic              wr_ok;

  logic [1:0]        rd_en;
  logic [ADDR_W-1:0] rd_addr   [2];
  logic [WIDTH-1:0]  rd_data_q [2];
  logic [WIDTH-1:0]  rd_data_d [2];
  logic [1:0]        rd_hit_q, rd_hit_d;
  logic [1:0]        rd_vld_q, rd_vld_d;

  assign wr_ok = wr_en && ({1'b0, wr_addr} < DepthC);

  assign rd_en      = {rd1_en, rd0_en};
  assign rd_addr[0] = rd0_addr;
  assign rd_addr[1] = rd1_addr;

  // Next storage/valid state: clear first, then the write so it wins its entry.
  always_comb begin
    mem_d   = mem_q;
    valid_d = clr ? '0 : valid_q;
    if (wr_ok) begin
      mem_d[wr_addr]   = (mem_q[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
      valid_d[wr_addr] = 1'b1;
    end
  end

  // Reads sample the post-write/post-clear state, which gives the bypass for free.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_vld_d[p]  = rd_en[p];
      rd_hit_d[p]  = rd_hit_q[p];
      rd_data_d[p] = rd_data_q[p];
      if (rd_en[p]) begin
        rd_hit_d[p]  = 1'b0;
        rd_data_d[p] = '0;
        if (({1'b0, rd_addr[p]} < DepthC) && valid_d[rd_addr[p]]) begin
          rd_hit_d[p]  = 1'b1;
          rd_data_d[p] = mem_d[rd_addr[p]];
        end
      end
    end
  end

  // State registers; synchronous reset clears data, valid bits and read outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      valid_q      <= '0;
      rd_data_q[0] <= '0;
      rd_data_q[1] <= '0;
      rd_hit_q     <= '0;
      rd_vld_q     <= '0;
    end else begin
      mem_q        <= mem_d;
      valid_q      <= valid_d;
      rd_data_q[0] <= rd_data_d[0];
      rd_data_q[1] <= rd_data_d[1];
      rd_hit_q     <= rd_hit_d;
      rd_vld_q     <= rd_vld_d;
    end
  end

  assign rd0_data  = rd_data_q[0];
  assign rd0_hit   = rd_hit_q[0];
  assign rd0_vld   = rd_vld_q[0];
  assign rd1_data  = rd_data_q[1];
  assign rd1_hit   = rd_hit_q[1];
  assign rd1_vld   = rd_vld_q[1];
  assign valid_vec = valid_q;

endmodule

// File: tb/tb_reg_file_nxw_2r1w.sv
// Self-checking bench for reg_file_nxw_2r1w (WIDTH=32, DEPTH=40, ADDR_W=6).
// Each driven cycle pushes the expected next-cycle outputs to a queue; the
// monitor step pops and compares after the clock edge.
module tb_reg_file_nxw_2r1w;

  localparam int W = 32;
  localparam int D = 40;
  localparam int A = 6;

  logic         clk = 1'b0;
  logic         rst, clr, wr_en, rd0_en, rd1_en;
  logic [A-1:0] wr_addr, rd0_addr, rd1_addr;
  logic [W-1:0] wr_data, wr_mask, rd0_data, rd1_data;
  logic         rd0_hit, rd0_vld, rd1_hit, rd1_vld;
  logic [D-1:0] valid_vec;

  reg_file_nxw_2r1w #(.WIDTH(W), .DEPTH(D), .ADDR_W(A)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(rd0_data),
    .rd0_hit(rd0_hit), .rd0_vld(rd0_vld),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_data),
    .rd1_hit(rd1_hit), .rd1_vld(rd1_vld),
    .valid_vec(valid_vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         vld0, hit0, vld1, hit1;
    logic [W-1:0] data0, data1;
    logic [D-1:0] vv;
  } exp_t;

  exp_t         exp_q[$];
  int           n_checks = 0;
  int           n_errors = 0;

  // Reference model state.
  logic [W-1:0] m_mem   [D];
  logic [D-1:0] m_valid;
  logic [W-1:0] m_hdata [2];
  logic         m_hhit  [2];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Model one read port against the post-write state.
  task automatic model_rd(input int p, input logic en, input logic [A-1:0] a,
                          output logic vld, output logic hit, output logic [W-1:0] data);
    if (en) begin
      m_hhit[p]  = (int'(a) < D) ? m_valid[a] : 1'b0;
      m_hdata[p] = m_hhit[p] ? m_mem[a] : '0;
    end
    vld  = en;
    hit  = m_hhit[p];
    data = m_hdata[p];
  endtask

  // Drive one cycle, push expectation, then pop and compare after the edge.
  task automatic cyc(input logic r, input logic c, input logic we, input logic [A-1:0] wa,
                     input logic [W-1:0] wd, input logic [W-1:0] wm,
                     input logic e0, input logic [A-1:0] a0,
                     input logic e1, input logic [A-1:0] a1);
    exp_t e;
    exp_t g;
    @(negedge clk);
    rst = r; clr = c; wr_en = we; wr_addr = wa; wr_data = wd; wr_mask = wm;
    rd0_en = e0; rd0_addr = a0; rd1_en = e1; rd1_addr = a1;
    if (r) begin
      for (int i = 0; i < D; i++) m_mem[i] = '0;
      m_valid = '0;
      for (int p = 0; p < 2; p++) begin
        m_hdata[p] = '0;
        m_hhit[p]  = 1'b0;
      end
      e = '{vld0: 1'b0, hit0: 1'b0, vld1: 1'b0, hit1: 1'b0, data0: '0, data1: '0, vv: '0};
    end else begin
      if (c) m_valid = '0;
      if (we && int'(wa) < D) begin
        m_mem[wa]   = (m_mem[wa] & ~wm) | (wd & wm);
        m_valid[wa] = 1'b1;
      end
      model_rd(0, e0, a0, e.vld0, e.hit0, e.data0);
      model_rd(1, e1, a1, e.vld1, e.hit1, e.data1);
      e.vv = m_valid;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    g = exp_q.pop_front();
    check_eq("rd0_vld", 64'(rd0_vld), 64'(g.vld0));
    check_eq("rd0_hit", 64'(rd0_hit), 64'(g.hit0));
    check_eq("rd0_data", 64'(rd0_data), 64'(g.data0));
    check_eq("rd1_vld", 64'(rd1_vld), 64'(g.vld1));
    check_eq("rd1_hit", 64'(rd1_hit), 64'(g.hit1));
    check_eq("rd1_data", 64'(rd1_data), 64'(g.data1));
    check_eq("valid_vec", 64'(valid_vec), 64'(g.vv));
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    for (int i = 0; i < D; i++) m_mem[i] = '0;
    m_valid = '0;
    m_hdata[0] = '0; m_hdata[1] = '0;
    m_hhit[0]  = 1'b0; m_hhit[1] = 1'b0;

    // Reset, then read every entry on both ports.
    cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < D; i++)
      cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, A'(i), 1'b1, A'(D - 1 - i));
    idle();

    // Masked merge on entry 5.
    cyc(1'b0, 1'b0, 1'b1, 6'd5, 32'hDEADBEEF, 32'hFFFFFFFF, 1'b0, '0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b1, 6'd5, 32'h00001234, 32'h0000FFFF, 1'b0, '0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 6'd5, 1'b0, '0);
    check_eq("tp_merge_data", 64'(rd0_data), 64'h00000000DEAD1234);
    check_eq("tp_merge_hit", 64'(rd0_hit), 64'd1);
    idle();  // hold values with rd_en low

    // Zero-mask write still sets valid; data untouched.
    cyc(1'b0, 1'b0, 1'b1, 6'd9, 32'hFFFFFFFF, 32'h0, 1'b1, 6'd9, 1'b0, '0);

    // Same-cycle bypass on both ports.
    cyc(1'b0, 1'b0, 1'b1, 6'd7, 32'hA5A5A5A5, 32'hFFFFFFFF, 1'b1, 6'd7, 1'b1, 6'd7);
    check_eq("tp_byp_d0", 64'(rd0_data), 64'h00000000A5A5A5A5);
    check_eq("tp_byp_d1", 64'(rd1_data), 64'h00000000A5A5A5A5);

    // Fill all entries, then clr together with a write to 3 and reads of 3/4.
    for (int i = 0; i < D; i++)
      cyc(1'b0, 1'b0, 1'b1, A'(i), $urandom, 32'hFFFFFFFF, 1'b0, '0, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b1, 6'd3, 32'h11, 32'hFFFFFFFF, 1'b1, 6'd3, 1'b1, 6'd4);
    check_eq("tp_clr_vv", 64'(valid_vec), 64'h8);
    check_eq("tp_clr_d3", 64'(rd0_data), 64'h11);
    check_eq("tp_clr_h4", 64'(rd1_hit), 64'd0);
    cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 6'd4, 1'b1, 6'd3);

    // Out-of-range writes and reads.
    cyc(1'b0, 1'b0, 1'b1, 6'd40, 32'hFF, 32'hFFFFFFFF, 1'b1, 6'd40, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b1, 6'd63, 32'hFF, 32'hFFFFFFFF, 1'b1, 6'd40, 1'b1, 6'd63);

    // Reset overrides everything in the same cycle.
    cyc(1'b1, 1'b1, 1'b1, 6'd12, 32'hCAFE, 32'hFFFFFFFF, 1'b1, 6'd12, 1'b1, 6'd3);
    cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 6'd12, 1'b1, 6'd3);

    // Random traffic including out-of-range addresses, clr and partial masks.
    for (int n = 0; n < 300; n++)
      cyc(1'b0, ($urandom_range(0, 19) == 0), 1'($urandom), A'($urandom), $urandom, $urandom,
          1'($urandom), A'($urandom_range(0, 45)), 1'($urandom), A'($urandom_range(0, 45)));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
